// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO; read data registered one cycle after the strobe.
// No backpressure: pushes into a full FIFO are dropped and flagged in the sticky overflow bit.
module uart_tx_periph #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'hA000_0000,
    parameter int unsigned     BAUD_DIV   = 868,
    parameter int unsigned     FIFO_DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            resetn_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic            mem_read_en_i,
    output logic [XLEN-1:0] mem_read_data_o,
    input  logic            mem_write_en_i,
    input  logic [XLEN-1:0] mem_write_data_i,
    output logic            uart_tx_o,
    output logic            tx_busy_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_DATA   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Register file and FIFO state
    logic            r_tx_en;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [XLEN-1:0] r_rdata;

    // Serializer state
    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;

    logic            w_sel;
    logic [1:0]      w_off;
    logic            w_wr;
    logic            w_rd;
    logic            w_ctrl_wr;
    logic            w_clr;
    logic            w_push;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_busy;
    logic            w_baud_end;
    logic [XLEN-1:0] w_status;
    logic [XLEN-1:0] w_rd_val;
    logic            w_unused_bits;

    assign w_sel      = (mem_addr_i[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign w_off      = mem_addr_i[3:2];
    assign w_wr       = mem_write_en_i && w_sel;
    assign w_rd       = mem_read_en_i && w_sel;
    assign w_ctrl_wr  = w_wr && (w_off == OFF_CTRL);
    assign w_clr      = w_ctrl_wr && mem_write_data_i[1];
    assign w_push     = w_wr && (w_off == OFF_DATA);

    assign w_full     = (r_count == COUNT_FULL);
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != S_IDLE);
    assign w_baud_end = (r_baud == BAUD_LAST);

    // Fullness is judged before any same-cycle pop; a clear overrides both sides.
    assign w_push_ok  = w_push && !w_full && !w_clr;
    assign w_pop      = (r_state == S_IDLE) && r_tx_en && !w_empty && !w_clr;

    assign w_unused_bits = ^{mem_addr_i[1:0], mem_write_data_i[XLEN-1:8]};

    always_comb begin
        w_status           = '0;
        w_status[0]        = w_busy;
        w_status[1]        = w_full;
        w_status[2]        = w_empty;
        w_status[3]        = r_overflow;
        w_status[8 +: CW]  = r_count;
    end

    always_comb begin
        w_rd_val = '0;
        case (w_off)
            OFF_CTRL:   w_rd_val[0] = r_tx_en;
            OFF_STATUS: w_rd_val    = w_status;
            default:    w_rd_val    = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= mem_write_data_i[7:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_tx_en    <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_tx_en <= mem_write_data_i[0];
            end

            if (w_clr) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_push_ok) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                if (w_push && w_full) begin
                    r_overflow <= 1'b1;
                end
                case ({w_push_ok, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end

            // Sampled before this edge's write lands, so a same-cycle write reads old data.
            r_rdata <= w_rd ? w_rd_val : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign mem_read_data_o = r_rdata;
    assign uart_tx_o       = r_tx;
    assign tx_busy_o       = w_busy;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboarded bench for uart_tx_periph: read and UART-line monitors check against queued expectations.
module tb_uart_tx_periph;

    localparam int B = 16;
    localparam logic [31:0] A_CTRL   = 32'hA000_0000;
    localparam logic [31:0] A_DATA   = 32'hA000_0004;
    localparam logic [31:0] A_STATUS = 32'hA000_0008;

    logic        clk_i = 1'b0;
    logic        resetn_i;
    logic [31:0] mem_addr_i;
    logic        mem_read_en_i;
    logic [31:0] mem_read_data_o;
    logic        mem_write_en_i;
    logic [31:0] mem_write_data_i;
    logic        uart_tx_o;
    logic        tx_busy_o;

    always #5 clk_i = ~clk_i;

    uart_tx_periph #(.XLEN(32), .BASE_ADDR(32'hA000_0000), .BAUD_DIV(B), .FIFO_DEPTH(16)) dut (
        .clk_i            (clk_i),
        .resetn_i         (resetn_i),
        .mem_addr_i       (mem_addr_i),
        .mem_read_en_i    (mem_read_en_i),
        .mem_read_data_o  (mem_read_data_o),
        .mem_write_en_i   (mem_write_en_i),
        .mem_write_data_i (mem_write_data_i),
        .uart_tx_o        (uart_tx_o),
        .tx_busy_o        (tx_busy_o)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [7:0]  uq_byte[$];
    bit          uq_gap[$];
    logic [31:0] rq_exp[$];
    string       rq_name[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic check_true(input string name, input bit cond);
        n_checks++;
        if (cond) n_pass++;
        else $display("FAIL %s: condition false, expected true", name);
    endtask

    // Read monitor: the cycle after a strobe must show the queued value, and the next idle cycle 0.
    bit          rm_was_rd;
    bit          rm_prev_rd = 1'b0;
    initial begin : rd_mon
        forever begin
            @(posedge clk_i);
            rm_was_rd = mem_read_en_i && resetn_i;
            #1;
            if (rm_was_rd) begin
                if (rq_exp.size() == 0) check_true("rd_expected", 1'b0 || rq_exp.size() != 0);
                else check(rq_name.pop_front(), mem_read_data_o, rq_exp.pop_front());
            end else if (rm_prev_rd) begin
                check("rd_after", mem_read_data_o, 32'h0);
            end
            rm_prev_rd = rm_was_rd;
        end
    end

    // Line monitor: checks each frame cycle by cycle, decodes at mid-bit, and checks spacing.
    int          um_start;
    int          um_last_start = -1;
    int          um_bad;
    bit          um_abort;
    bit          um_gap;
    logic [7:0]  um_exp;
    logic [7:0]  um_rx;
    logic        um_lvl;
    initial begin : uart_mon
        forever begin
            @(posedge clk_i);
            #1;
            if (resetn_i && uart_tx_o == 1'b0) begin
                um_start = cyc;
                if (uq_byte.size() == 0) begin
                    check_true("frame_expected", uq_byte.size() != 0);
                    for (int w = 0; w < 10 * B && uart_tx_o == 1'b0; w++) begin
                        @(posedge clk_i);
                        #1;
                    end
                end else begin
                    um_exp   = uq_byte.pop_front();
                    um_gap   = uq_gap.pop_front();
                    um_bad   = 0;
                    um_abort = 1'b0;
                    um_rx    = 8'h00;
                    if (um_gap) check("frame_gap", um_start - um_last_start, 10 * B + 1);
                    for (int i = 0; i < 10 * B; i++) begin
                        if (i > 0) begin
                            @(posedge clk_i);
                            #1;
                        end
                        if (!resetn_i) begin
                            um_abort = 1'b1;
                            break;
                        end
                        if (i / B == 0) um_lvl = 1'b0;
                        else if (i / B == 9) um_lvl = 1'b1;
                        else um_lvl = um_exp[i / B - 1];
                        if (uart_tx_o !== um_lvl || tx_busy_o !== 1'b1) um_bad++;
                        if (i % B == B / 2 && i / B >= 1 && i / B <= 8) um_rx[i / B - 1] = uart_tx_o;
                    end
                    if (!um_abort) begin
                        check("frame_wave", um_bad, 0);
                        check("frame_byte", {24'h0, um_rx}, {24'h0, um_exp});
                        @(posedge clk_i);
                        #1;
                        check("frame_idle_gap", {30'h0, uart_tx_o, tx_busy_o}, 32'h2);
                        um_last_start = um_start;
                    end
                end
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        mem_addr_i = a; mem_write_data_i = d; mem_write_en_i = 1'b1;
        @(negedge clk_i);
        mem_write_en_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        @(negedge clk_i);
        rq_exp.push_back(exp); rq_name.push_back(name);
        mem_addr_i = a; mem_read_en_i = 1'b1;
        @(negedge clk_i);
        mem_read_en_i = 1'b0;
    endtask

    task automatic rdwr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp, input string name);
        @(negedge clk_i);
        rq_exp.push_back(exp); rq_name.push_back(name);
        mem_addr_i = a; mem_write_data_i = d; mem_read_en_i = 1'b1; mem_write_en_i = 1'b1;
        @(negedge clk_i);
        mem_read_en_i = 1'b0; mem_write_en_i = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] b, input bit gap);
        uq_byte.push_back(b);
        uq_gap.push_back(gap);
    endtask

    task automatic wait_idle(input int limit, input string name);
        int n = 0;
        while ((uq_byte.size() != 0 || tx_busy_o) && n < limit) begin
            @(negedge clk_i);
            n++;
        end
        check_true(name, n < limit);
        repeat (3) @(negedge clk_i);
    endtask

    logic [7:0] msg [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                             8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    int hold_hi;

    initial begin : stim
        resetn_i = 1'b0; mem_addr_i = '0; mem_read_en_i = 1'b0;
        mem_write_en_i = 1'b0; mem_write_data_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_tx", {31'h0, uart_tx_o}, 32'h1);
        check("rst_busy", {31'h0, tx_busy_o}, 32'h0);
        check("rst_rdata", mem_read_data_o, 32'h0);
        resetn_i = 1'b1;
        rd(A_STATUS, 32'h0000_0004, "status_reset");
        rd(A_CTRL, 32'h0, "ctrl_reset");

        // Single byte 0x48
        expect_frame(8'h48, 1'b0);
        wr(A_DATA, 32'h48);
        wr(A_CTRL, 32'h1);
        repeat (B) @(negedge clk_i);
        rd(A_STATUS, 32'h0000_0005, "status_busy");
        wait_idle(12 * B, "single_done");

        // "Hello World!" back to back
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 12; i++) begin
            expect_frame(msg[i], i != 0);
            wr(A_DATA, {24'h0, msg[i]});
        end
        rd(A_STATUS, 32'h0000_0C00, "status_12");
        wr(A_CTRL, 32'h1);
        wait_idle(13 * (10 * B + 1) + 20, "hello_done");

        // Overflow and clear
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < 17; i++) wr(A_DATA, 32'h30 + i);
        rd(A_STATUS, 32'h0000_100A, "status_overflow");
        wr(A_CTRL, 32'h2);
        rd(A_STATUS, 32'h0000_0004, "status_cleared");
        rd(A_CTRL, 32'h0, "ctrl_clr_reads0");

        // Disable mid-frame
        expect_frame(8'hA1, 1'b0);
        wr(A_DATA, 32'hA1); wr(A_DATA, 32'hB2); wr(A_DATA, 32'hC3);
        wr(A_CTRL, 32'h1);
        repeat (2 * B) @(negedge clk_i);
        wr(A_CTRL, 32'h0);
        wait_idle(12 * B, "disable_done");
        hold_hi = 0;
        for (int i = 0; i < 30 * B; i++) begin
            @(negedge clk_i);
            if (uart_tx_o && !tx_busy_o) hold_hi++;
        end
        check("disable_hold", hold_hi, 30 * B);
        rd(A_STATUS, 32'h0000_0200, "status_disabled");
        wr(A_CTRL, 32'h2);

        // Decode and read latency
        rd(32'hA000_0010, 32'h0, "rd_unselected");
        wr(32'hA000_0010, 32'h55);
        wr(32'hA000_000C, 32'h55);
        rd(A_STATUS, 32'h0000_0004, "status_no_decode");
        wr(32'hA000_0007, 32'h5A);
        rd(A_STATUS, 32'h0000_0100, "status_lowbits_ignored");
        rd(A_DATA, 32'h0, "rd_data_reg");
        rd(32'hA000_000C, 32'h0, "rd_reserved");
        wr(A_CTRL, 32'h2);
        rd(A_STATUS, 32'h0000_0004, "status_clr2");
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, 32'h1, "ctrl_readback");
        rdwr(A_CTRL, 32'h0, 32'h1, "rdwr_prewrite");
        rd(A_CTRL, 32'h0, "ctrl_after_rdwr");

        // Reset mid-frame
        expect_frame(8'hA5, 1'b0);
        wr(A_DATA, 32'hA5);
        wr(A_CTRL, 32'h1);
        repeat (3 * B) @(negedge clk_i);
        check("midframe_busy", {31'h0, tx_busy_o}, 32'h1);
        resetn_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("rst_mid_tx", {31'h0, uart_tx_o}, 32'h1);
        check("rst_mid_busy", {31'h0, tx_busy_o}, 32'h0);
        check("rst_mid_rdata", mem_read_data_o, 32'h0);
        @(negedge clk_i);
        resetn_i = 1'b1;
        rd(A_STATUS, 32'h0000_0004, "status_after_rst");
        rd(A_CTRL, 32'h0, "ctrl_after_rst");
        repeat (12 * B) @(negedge clk_i);
        check("no_frame_after_rst", {31'h0, uart_tx_o}, 32'h1);
        check("queues_drained", uq_byte.size() + rq_exp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation still running at %0d cycles, limit 50000", cyc);
        $fatal(1);
    end

endmodule
